key_input_conditioner: RTL and testbench

- Input-side counterpart to the board's LED/HEX output path.
- Turns raw, bouncing, active-low push-buttons (KEY[1:0]) into clean, synchronous per-key events: press pulse, release pulse, long-press pulse, plus level flags.
- The light-show state machine and pattern logic consume these events instead of sampling KEY directly.
- Keys are fully independent; each has its own synchronizer, state machine and counters.

---
 rtl/key_input_conditioner.sv | 176 +++++++++++++++++
 tb/tb_key_input_conditioner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Per-key push-button conditioner: two-flop synchronizer, debounce FSM and
// long-press timer, producing registered level flags and one-cycle event
// pulses for downstream control logic.
module key_input_conditioner #(
  parameter int unsigned N_KEYS            = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_held
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HL_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HL_W-1:0] HL_LAST = HL_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [HL_W-1:0] HL_ONE  = HL_W'(1);

  typedef enum logic [2:0] {
    ST_UP,
    ST_DB_DOWN,
    ST_DOWN,
    ST_LONG,
    ST_DB_UP
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pressed;

  state_t            state       [N_KEYS];
  state_t            state_nxt   [N_KEYS];
  logic [DB_W-1:0]   db_cnt      [N_KEYS];
  logic [DB_W-1:0]   db_cnt_nxt  [N_KEYS];
  logic [HL_W-1:0]   hold_cnt    [N_KEYS];
  logic [HL_W-1:0]   hold_cnt_nxt[N_KEYS];
  logic [N_KEYS-1:0] long_seen;
  logic [N_KEYS-1:0] long_seen_nxt;

  logic [N_KEYS-1:0] level_nxt;
  logic [N_KEYS-1:0] press_nxt;
  logic [N_KEYS-1:0] release_nxt;
  logic [N_KEYS-1:0] long_nxt;
  logic [N_KEYS-1:0] held_nxt;

  // Two-flop synchronizer; resets to the released electrical level.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      sync1 <= {N_KEYS{ACTIVE_LOW}};
      sync2 <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

  // Per-key FSM state and counter registers.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        state[k]    <= ST_UP;
        db_cnt[k]   <= '0;
        hold_cnt[k] <= '0;
      end
      long_seen <= '0;
    end else begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        state[k]    <= state_nxt[k];
        db_cnt[k]   <= db_cnt_nxt[k];
        hold_cnt[k] <= hold_cnt_nxt[k];
      end
      long_seen <= long_seen_nxt;
    end
  end

  // Next-state, counter updates and event decode for every key.
  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    long_seen_nxt = long_seen;
    level_nxt     = '0;
    press_nxt     = '0;
    release_nxt   = '0;
    long_nxt      = '0;
    held_nxt      = '0;
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      unique case (state[k])
        ST_UP: begin
          if (pressed[k]) begin
            state_nxt[k]  = ST_DB_DOWN;
            db_cnt_nxt[k] = '0;
          end
        end
        ST_DB_DOWN: begin
          if (!pressed[k]) begin
            state_nxt[k] = ST_UP;
          end else if (db_cnt[k] == DB_LAST) begin
            state_nxt[k]    = ST_DOWN;
            press_nxt[k]    = 1'b1;
            hold_cnt_nxt[k] = '0;
          end else begin
            db_cnt_nxt[k] = db_cnt[k] + DB_ONE;
          end
        end
        ST_DOWN: begin
          if (!pressed[k]) begin
            state_nxt[k]  = ST_DB_UP;
            db_cnt_nxt[k] = '0;
          end else if (hold_cnt[k] == HL_LAST) begin
            state_nxt[k]     = ST_LONG;
            long_nxt[k]      = 1'b1;
            long_seen_nxt[k] = 1'b1;
          end else begin
            hold_cnt_nxt[k] = hold_cnt[k] + HL_ONE;
          end
        end
        ST_LONG: begin
          if (!pressed[k]) begin
            state_nxt[k]  = ST_DB_UP;
            db_cnt_nxt[k] = '0;
          end
        end
        ST_DB_UP: begin
          // A bounce back to pressed resumes the hold phase without restarting it.
          if (pressed[k]) begin
            state_nxt[k] = long_seen[k] ? ST_LONG : ST_DOWN;
          end else if (db_cnt[k] == DB_LAST) begin
            state_nxt[k]     = ST_UP;
            release_nxt[k]   = 1'b1;
            long_seen_nxt[k] = 1'b0;
          end else begin
            db_cnt_nxt[k] = db_cnt[k] + DB_ONE;
          end
        end
        default: begin
          state_nxt[k] = ST_UP;
        end
      endcase
      // Level flags are decoded from the next state so they align with the pulses.
      level_nxt[k] = (state_nxt[k] == ST_DOWN) || (state_nxt[k] == ST_LONG) ||
                     (state_nxt[k] == ST_DB_UP);
      held_nxt[k]  = (state_nxt[k] == ST_LONG) ||
                     ((state_nxt[k] == ST_DB_UP) && long_seen_nxt[k]);
    end
  end

  // Registered outputs.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_held    <= '0;
    end else begin
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
      key_held    <= held_nxt;
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with short debounce/long-press
// thresholds; expected outputs are written per cycle from edge counts.
module tb_key_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;
  logic [1:0] key_held;

  int checks   = 0;
  int failures = 0;

  key_input_conditioner #(
    .N_KEYS            (2),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .KEY           (KEY),
    .key_level     (key_level),
    .key_press     (key_press),
    .key_release   (key_release),
    .key_long      (key_long),
    .key_held      (key_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag,
                            input logic [1:0] e_lvl, input logic [1:0] e_prs,
                            input logic [1:0] e_rel, input logic [1:0] e_lng,
                            input logic [1:0] e_hld);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {key_level, key_press, key_release, key_long, key_held};
    exp = {e_lvl, e_prs, e_rel, e_lng, e_hld};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: lvl/prs/rel/lng/hld observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    KEY   = 2'b11;
    tick();
    tick();
    check_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    tick();
    check_outs("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Clean press and release on key 0.
    KEY = 2'b10;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_outs($sformatf("press0_e%0d", e), {1'b0, e >= 7}, {1'b0, e == 7},
                 2'b00, 2'b00, 2'b00);
    end
    KEY = 2'b11;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_outs($sformatf("rel0_e%0d", e), {1'b0, e < 7}, 2'b00,
                 {1'b0, e == 7}, 2'b00, 2'b00);
    end

    // Bounce on key 0: never stable for four samples.
    for (int c = 0; c < 30; c++) begin
      KEY[0] = ((c / 2) % 2) != 0;
      tick();
      check_outs($sformatf("bounce_c%0d", c), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    KEY = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_outs($sformatf("bounce_tail_e%0d", e), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Long press on key 1.
    KEY = 2'b01;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check_outs($sformatf("long1_e%0d", e), {e >= 7, 1'b0}, {e == 7, 1'b0},
                 2'b00, {e == 27, 1'b0}, {e >= 27, 1'b0});
    end

    // Two-clock release glitch while in the long-press state.
    KEY = 2'b11;
    for (int g = 1; g <= 10; g++) begin
      tick();
      if (g == 2) KEY = 2'b01;
      check_outs($sformatf("glitch1_g%0d", g), 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    end

    // Release of the long press.
    KEY = 2'b11;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_outs($sformatf("rel1_e%0d", e), {e < 7, 1'b0}, 2'b00,
                 {e == 7, 1'b0}, 2'b00, {e < 7, 1'b0});
    end

    // Reset while key 0 is held.
    KEY = 2'b10;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_outs($sformatf("pre_rst_e%0d", e), {1'b0, e >= 7}, {1'b0, e == 7},
                 2'b00, 2'b00, 2'b00);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int e = 1; e <= 30; e++) begin
      tick();
      check_outs($sformatf("post_rst_e%0d", e), {1'b0, e >= 7}, {1'b0, e == 7},
                 2'b00, {1'b0, e == 27}, {1'b0, e >= 27});
    end
    KEY = 2'b11;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_outs($sformatf("post_rst_rel_e%0d", e), {1'b0, e < 7}, 2'b00,
                 {1'b0, e == 7}, 2'b00, {1'b0, e < 7});
    end

    // Both keys pressed together, released at different times.
    KEY = 2'b00;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check_outs($sformatf("both_e%0d", e), {2{e >= 7}}, {2{e == 7}},
                 2'b00, {2{e == 27}}, {2{e >= 27}});
    end
    KEY = 2'b01;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 3) KEY = 2'b11;
      check_outs($sformatf("both_rel_e%0d", e), {e < 10, e < 7}, 2'b00,
                 {e == 10, e == 7}, 2'b00, {e < 10, e < 7});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
